fp_multiplier_pipe: RTL and testbench

- Parametrised, 3-stage pipelined IEEE-754 binary multiplier; successor to the combinational single-precision multiplier in the FP ALU.
- Adds generic exponent/mantissa widths, round-to-nearest-even, special-operand handling, exception flags and valid/ready flow control.
- Sits between the ALU operand-issue logic and the result mux.

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_round_norm.sv | 55 +++++
 rtl/fp_multiplier_pipe.sv | 195 +++++++++++++++++++
 tb/tb_fp_multiplier_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared operand classes, flag positions and constant helpers for the
// parametrised IEEE-754 datapaths.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  // Bit positions inside the 4-bit {invalid, overflow, underflow, inexact} flag word
  localparam int unsigned FLG_INV = 3;
  localparam int unsigned FLG_OVF = 2;
  localparam int unsigned FLG_UNF = 1;
  localparam int unsigned FLG_INX = 0;

  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

  // Canonical quiet NaN right-aligned in 64 bits; callers keep the low W bits.
  function automatic logic [63:0] qnan(input int unsigned exp_w, input int unsigned man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 32'd1));
  endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Combinational normalise / round-to-nearest-even / range-check / pack for a
// double-width significand product. Shared with the adder pipeline.
module fp_round_norm
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                    sign_i,
  input  logic signed [EXP_W+1:0] exp_i,
  input  logic [2*MAN_W+1:0]      prod_i,
  output logic [EXP_W+MAN_W:0]    res_o,
  output logic [3:0]              flags_o
);

  localparam int unsigned EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  logic                 msb;
  logic [2*MAN_W-1:0]   norm;
  logic [MAN_W-1:0]     frac;
  logic                 guard;
  logic                 sticky;
  logic                 rnd_up;
  logic [MAN_W:0]       frac_r;
  logic signed [EW-1:0] e_n;

  always_comb begin
    // norm drops the hidden bit; a set product MSB means value in [2,4)
    msb    = prod_i[2*MAN_W+1];
    norm   = msb ? prod_i[2*MAN_W:1] : prod_i[2*MAN_W-1:0];
    frac   = norm[2*MAN_W-1:MAN_W];
    guard  = norm[MAN_W-1];
    sticky = (|norm[MAN_W-2:0]) | (msb & prod_i[0]);
    rnd_up = guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_up};
    // A carry out of the fraction means 1.11..1 rounded to 10.0: fraction is already zero
    e_n    = exp_i + $signed({{(EW-1){1'b0}}, msb}) + $signed({{(EW-1){1'b0}}, frac_r[MAN_W]});

    res_o            = {sign_i, e_n[EXP_W-1:0], frac_r[MAN_W-1:0]};
    flags_o          = '0;
    flags_o[FLG_INX] = guard | sticky;

    if (!e_n[EW-1] && (e_n >= EMAX)) begin
      res_o            = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_o[FLG_OVF] = 1'b1;
      flags_o[FLG_INX] = 1'b1;
    end else if (e_n[EW-1] || (e_n == '0)) begin
      res_o            = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      flags_o[FLG_UNF] = 1'b1;
      flags_o[FLG_INX] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_multiplier_pipe.sv
// Three-stage pipelined IEEE-754 multiplier (classify / multiply / round-pack)
// with elastic valid/ready handshakes and flush-to-zero subnormal handling.
module fp_multiplier_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_res,
  output logic [3:0]             out_flags
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam logic [63:0]          QNAN_FULL = qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN      = QNAN_FULL[W-1:0];
  localparam logic signed [EW-1:0] BIAS_E    = EW'(bias(EXP_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return FP_ZERO;
    if (e == '1) return (f == '0) ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  fp_class_e        ca, cb, cls_in;
  logic             inv_in;
  logic             ld1, ld2, ld3;

  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  fp_class_e            cls1_q, cls1_d, cls2_q, cls2_d;
  logic                 inv1_q, inv1_d, inv2_q, inv2_d;
  logic                 sgn1_q, sgn1_d, sgn2_q, sgn2_d;
  logic signed [EW-1:0] e1_q, e1_d, e2_q, e2_d;
  logic [MAN_W:0]       ma1_q, ma1_d, mb1_q, mb1_d;
  logic [PW-1:0]        prod2_q, prod2_d;
  logic [W-1:0]         res3_q, res3_d;
  logic [3:0]           flg3_q, flg3_d;

  logic [W-1:0] rn_res, s3_res;
  logic [3:0]   rn_flg, s3_flg;

  assign {sa, ea, fa} = in_a;
  assign {sb, eb, fb} = in_b;

  // Each stage advances when empty or when its successor advances
  assign ld3      = !v3_q || out_ready;
  assign ld2      = !v2_q || ld3;
  assign ld1      = !v1_q || ld2;
  assign in_ready = ld1;

  assign out_valid = v3_q;
  assign out_res   = res3_q;
  assign out_flags = flg3_q;

  always_comb begin
    ca     = classify(ea, fa);
    cb     = classify(eb, fb);
    cls_in = FP_NORM;
    inv_in = 1'b0;
    if (ca == FP_NAN || cb == FP_NAN) begin
      cls_in = FP_NAN;
      inv_in = (ca == FP_NAN && !fa[MAN_W-1]) || (cb == FP_NAN && !fb[MAN_W-1]);
    end else if ((ca == FP_ZERO && cb == FP_INF) || (ca == FP_INF && cb == FP_ZERO)) begin
      cls_in = FP_NAN;
      inv_in = 1'b1;
    end else if (ca == FP_INF || cb == FP_INF) begin
      cls_in = FP_INF;
    end else if (ca == FP_ZERO || cb == FP_ZERO) begin
      cls_in = FP_ZERO;
    end
  end

  fp_round_norm #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_round_norm (
    .sign_i (sgn2_q),
    .exp_i  (e2_q),
    .prod_i (prod2_q),
    .res_o  (rn_res),
    .flags_o(rn_flg)
  );

  always_comb begin
    s3_res = rn_res;
    s3_flg = rn_flg;
    case (cls2_q)
      FP_NAN: begin
        s3_res          = QNAN;
        s3_flg          = '0;
        s3_flg[FLG_INV] = inv2_q;
      end
      FP_INF: begin
        s3_res = {sgn2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        s3_flg = '0;
      end
      FP_ZERO: begin
        s3_res = {sgn2_q, {(EXP_W+MAN_W){1'b0}}};
        s3_flg = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    v1_d    = ld1 ? in_valid : v1_q;
    cls1_d  = cls1_q;
    inv1_d  = inv1_q;
    sgn1_d  = sgn1_q;
    e1_d    = e1_q;
    ma1_d   = ma1_q;
    mb1_d   = mb1_q;
    if (ld1 && in_valid) begin
      cls1_d = cls_in;
      inv1_d = inv_in;
      sgn1_d = sa ^ sb;
      e1_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;
      ma1_d  = {1'b1, fa};
      mb1_d  = {1'b1, fb};
    end

    v2_d    = ld2 ? v1_q : v2_q;
    cls2_d  = cls2_q;
    inv2_d  = inv2_q;
    sgn2_d  = sgn2_q;
    e2_d    = e2_q;
    prod2_d = prod2_q;
    if (ld2 && v1_q) begin
      cls2_d  = cls1_q;
      inv2_d  = inv1_q;
      sgn2_d  = sgn1_q;
      e2_d    = e1_q;
      prod2_d = PW'(ma1_q) * PW'(mb1_q);
    end

    v3_d   = ld3 ? v2_q : v3_q;
    res3_d = res3_q;
    flg3_d = flg3_q;
    if (ld3 && v2_q) begin
      res3_d = s3_res;
      flg3_d = s3_flg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      cls1_q  <= FP_ZERO;
      cls2_q  <= FP_ZERO;
      inv1_q  <= 1'b0;
      inv2_q  <= 1'b0;
      sgn1_q  <= 1'b0;
      sgn2_q  <= 1'b0;
      e1_q    <= '0;
      e2_q    <= '0;
      ma1_q   <= '0;
      mb1_q   <= '0;
      prod2_q <= '0;
      res3_q  <= '0;
      flg3_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      cls1_q  <= cls1_d;
      cls2_q  <= cls2_d;
      inv1_q  <= inv1_d;
      inv2_q  <= inv2_d;
      sgn1_q  <= sgn1_d;
      sgn2_q  <= sgn2_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      ma1_q   <= ma1_d;
      mb1_q   <= mb1_d;
      prod2_q <= prod2_d;
      res3_q  <= res3_d;
      flg3_q  <= flg3_d;
    end
  end

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Self-checking bench for fp_multiplier_pipe: directed IEEE cases, flow control,
// reset behaviour, half precision and randomized traffic against a reference model.
module tb_fp_multiplier_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_res;
  logic [3:0]  out_flags;
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_in_a, h_in_b, h_out_res;
  logic [3:0]  h_out_flags;

  int n_cmp = 0;
  int n_bad = 0;

  fp_multiplier_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_flags(out_flags)
  );

  fp_multiplier_pipe #(
    .EXP_W(5),
    .MAN_W(10)
  ) dut_h (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (h_in_valid),
    .in_ready (h_in_ready),
    .in_a     (h_in_a),
    .in_b     (h_in_b),
    .out_valid(h_out_valid),
    .out_ready(h_out_ready),
    .out_res  (h_out_res),
    .out_flags(h_out_flags)
  );

  // Reference: exact integer product rounded to (mw+1) significant bits.
  function automatic void model(input int unsigned ew, input int unsigned mw,
                                input longint unsigned a, input longint unsigned b,
                                output longint unsigned r, output logic [3:0] f);
    longint unsigned emax, bs, mmask, ea, eb, fa, fb, sgn, qn, p, q, rem, half;
    longint signed   ex;
    int unsigned     len, sh;
    bit na, nb, sna, snb, ia, ib, za, zb;
    emax  = (64'd1 << ew) - 1;
    bs    = (64'd1 << (ew - 1)) - 1;
    mmask = (64'd1 << mw) - 1;
    sgn   = ((a >> (ew + mw)) ^ (b >> (ew + mw))) & 64'd1;
    ea = (a >> mw) & emax;  eb = (b >> mw) & emax;
    fa = a & mmask;         fb = b & mmask;
    qn  = (emax << mw) | (64'd1 << (mw - 1));
    na  = (ea == emax) && (fa != 0);  nb = (eb == emax) && (fb != 0);
    sna = na && !fa[mw-1];            snb = nb && !fb[mw-1];
    ia  = (ea == emax) && (fa == 0);  ib = (eb == emax) && (fb == 0);
    za  = (ea == 0);                  zb = (eb == 0);
    f = 4'b0000;
    r = 0;
    if (na || nb) begin
      r = qn; f[3] = sna || snb;
    end else if ((ia && zb) || (za && ib)) begin
      r = qn; f[3] = 1'b1;
    end else if (ia || ib) begin
      r = (sgn << (ew + mw)) | (emax << mw);
    end else if (za || zb) begin
      r = sgn << (ew + mw);
    end else begin
      p = ((64'd1 << mw) | fa) * ((64'd1 << mw) | fb);
      len = 0;
      for (int unsigned i = 0; i < 64; i++) if (p[i]) len = i + 1;
      sh   = len - (mw + 1);
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << (mw + 1))) begin q = q >> 1; sh++; end
      ex = $signed(ea) + $signed(eb) - $signed(bs) + longint'(sh) - longint'(mw);
      if (ex >= $signed(emax)) begin
        r = (sgn << (ew + mw)) | (emax << mw); f = 4'b0101;
      end else if (ex <= 0) begin
        r = sgn << (ew + mw); f = 4'b0011;
      end else begin
        r = (sgn << (ew + mw)) | ($unsigned(ex) << mw) | (q & mmask);
        f[0] = (rem != 0);
      end
    end
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 15))
      0:       v[30:23] = 8'h00;
      1:       v[30:23] = 8'hFF;
      2:       v[30:0]  = {8'hFF, 23'h0};
      3:       v[30:23] = 8'($urandom_range(1, 40));
      4:       v[30:23] = 8'($urandom_range(215, 254));
      default: v[30:23] = 8'($urandom_range(90, 164));
    endcase
    return v;
  endfunction

  function automatic logic [31:0] rnd_norm();
    logic [31:0] v;
    v = $urandom;
    v[30:23] = 8'($urandom_range(100, 150));
    return v;
  endfunction

  // Drives one operand pair into the chosen DUT and reports cycles until out_valid.
  task automatic send_op(input bit half, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [3:0] flg, output int lat);
    int waited;
    bit acc;
    res = '0; flg = '0; lat = -1;
    @(posedge clk); #1;
    out_ready = 1'b1; h_out_ready = 1'b1;
    if (half) begin h_in_valid = 1'b1; h_in_a = a[15:0]; h_in_b = b[15:0]; end
    else      begin in_valid = 1'b1;   in_a = a;         in_b = b;         end
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
      acc = half ? h_in_ready : in_ready;
    end while (!acc && waited < 20);
    @(posedge clk); #1;
    in_valid = 1'b0; h_in_valid = 1'b0;
    if (acc) begin
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (half ? h_out_valid : out_valid) begin
          lat = c;
          res = half ? {16'h0, h_out_res} : out_res;
          flg = half ? h_out_flags : out_flags;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_res !== 32'h0) begin n_bad++; $display("FAIL reset_out_res: got %h want 00000000", out_res); end
    n_cmp++; if (out_flags !== 4'h0) begin n_bad++; $display("FAIL reset_out_flags: got %b want 0000", out_flags); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (h_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_half_out_valid: got %b want 0", h_out_valid); end
  endtask

  localparam int ND = 15;
  localparam logic [31:0] DA [ND] = '{32'h3FC00000, 32'h3F800001, 32'h3FFFFFFF, 32'h3F800001, 32'h3F800003,
                                      32'h7F7FFFFF, 32'h00800000, 32'h80800000, 32'h00000000, 32'h7FC00001,
                                      32'h7F800001, 32'h00000001, 32'h7F800000, 32'h00000000, 32'h7FC00000};
  localparam logic [31:0] DB [ND] = '{32'h40000000, 32'h3F800001, 32'h3FFFFFFF, 32'h3FC00000, 32'h3FC00000,
                                      32'h40000000, 32'h3F000000, 32'h3F000000, 32'hFF800000, 32'h3F800000,
                                      32'h3F800000, 32'h3F800000, 32'hC0000000, 32'hC0000000, 32'h00000000};
  localparam logic [31:0] DR [ND] = '{32'h40400000, 32'h3F800002, 32'h407FFFFE, 32'h3FC00002, 32'h3FC00004,
                                      32'h7F800000, 32'h00000000, 32'h80000000, 32'h7FC00000, 32'h7FC00000,
                                      32'h7FC00000, 32'h00000000, 32'hFF800000, 32'h80000000, 32'h7FC00000};
  localparam logic [3:0]  DF [ND] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                      4'b0101, 4'b0011, 4'b0011, 4'b1000, 4'b0000,
                                      4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

  task automatic test_directed();
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    for (int i = 0; i < ND; i++) begin
      send_op(1'b0, DA[i], DB[i], res, flg, lat);
      n_cmp++; if (res !== DR[i]) begin n_bad++; $display("FAIL dir%0d_res: %h x %h got %h want %h", i, DA[i], DB[i], res, DR[i]); end
      n_cmp++; if (flg !== DF[i]) begin n_bad++; $display("FAIL dir%0d_flags: got %b want %b", i, flg, DF[i]); end
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want 3", i, lat); end
    end
  endtask

  task automatic test_half();
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    send_op(1'b1, 32'h3E00, 32'h4000, res, flg, lat);
    n_cmp++; if (res !== 32'h4200) begin n_bad++; $display("FAIL half_mul_res: got %h want 4200", res); end
    n_cmp++; if (flg !== 4'b0000) begin n_bad++; $display("FAIL half_mul_flags: got %b want 0000", flg); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL half_mul_latency: got %0d want 3", lat); end
    send_op(1'b1, 32'h7BFF, 32'h4000, res, flg, lat);
    n_cmp++; if (res !== 32'h7C00) begin n_bad++; $display("FAIL half_ovf_res: got %h want 7c00", res); end
    n_cmp++; if (flg !== 4'b0101) begin n_bad++; $display("FAIL half_ovf_flags: got %b want 0101", flg); end
  endtask

  task automatic test_backpressure();
    logic [31:0]     oa [5], ob [5], er [5];
    logic [3:0]      ef [5];
    longint unsigned r;
    logic [3:0]      f;
    int              idx, nout, first, last;
    for (int i = 0; i < 5; i++) begin
      oa[i] = rnd_norm(); ob[i] = rnd_norm();
      model(8, 23, oa[i], ob[i], r, f);
      er[i] = r[31:0]; ef[i] = f;
    end
    idx = 0; nout = 0; first = -1; last = -1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = (idx < 5);
      in_a = oa[(idx < 5) ? idx : 4]; in_b = ob[(idx < 5) ? idx : 4];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (c >= 3) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_res !== er[0] || out_flags !== ef[0]) begin
          n_bad++;
          $display("FAIL bp_stall_hold c%0d: got v=%b %h/%b want v=1 %h/%b", c, out_valid, out_res, out_flags, er[0], ef[0]);
        end
      end
    end
    n_cmp++; if (idx !== 3) begin n_bad++; $display("FAIL bp_accept_count: got %0d want 3", idx); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = (idx < 5);
      in_a = oa[(idx < 5) ? idx : 4]; in_b = ob[(idx < 5) ? idx : 4];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        n_cmp++;
        if (nout >= 5) begin
          n_bad++; $display("FAIL bp_extra_result: got %h want none", out_res);
        end else if (out_res !== er[nout] || out_flags !== ef[nout]) begin
          n_bad++; $display("FAIL bp_result%0d: got %h/%b want %h/%b", nout, out_res, out_flags, er[nout], ef[nout]);
        end
        if (first < 0) first = c;
        last = c;
        nout++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (nout !== 5) begin n_bad++; $display("FAIL bp_result_count: got %0d want 5", nout); end
    n_cmp++; if (last - first !== 4) begin n_bad++; $display("FAIL bp_one_per_cycle: got span %0d want 4", last - first); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat, stale;
    bit          seen;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'h3FC00000; in_b = 32'h40000000;
    @(negedge clk);
    @(posedge clk); #1;
    in_a = 32'h40400000; in_b = 32'h40400000;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL midrst_inflight_valid: got 0 want 1"); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_async_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_res !== 32'h0) begin n_bad++; $display("FAIL midrst_async_res: got %h want 00000000", out_res); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_bad++; $display("FAIL midrst_stale: got %0d results want 0", stale); end
    send_op(1'b0, 32'h40400000, 32'h3F000000, res, flg, lat);
    n_cmp++; if (res !== 32'h3FC00000) begin n_bad++; $display("FAIL midrst_new_res: got %h want 3fc00000", res); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL midrst_new_latency: got %0d want 3", lat); end
  endtask

  task automatic test_random();
    logic [35:0]     q [$];
    longint unsigned r;
    logic [3:0]      f;
    for (int c = 0; c < 620; c++) begin
      @(posedge clk); #1;
      if (c < 600) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_a      = rnd_op();
        in_b      = rnd_op();
        out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (out_valid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL rnd_unexpected: got %h want no result", out_res);
        end else if ({out_flags, out_res} !== q[0]) begin
          n_bad++; $display("FAIL rnd_result: got %h/%b want %h/%b", out_res, out_flags, q[0][31:0], q[0][35:32]);
        end
        if (out_ready && q.size() > 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        model(8, 23, in_a, in_b, r, f);
        q.push_back({f, r[31:0]});
      end
    end
    n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL rnd_drain: got %0d pending want 0", q.size()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_out_ready = 1'b1;
    test_reset();
    test_directed();
    test_half();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
